// File: rtl/uart_packet_sender.sv
// rtl/uart_packet_sender.sv - queues detection records and frames each one as a 7-byte UART packet
module uart_packet_sender #(
    parameter logic [7:0] HEADER = 8'hA5,
    parameter int         DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rec_valid,
    input  logic [15:0]              rec_x,
    input  logic [15:0]              rec_y,
    input  logic [7:0]               rec_scale,
    output logic                     rec_ready,
    output logic [7:0]               uart_data,
    output logic                     send_uart_data,
    input  logic                     uart_data_sent,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t        state;
    logic [39:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [55:0]   packet;
    logic [2:0]    index;
    logic          push;
    logic          pop;
    logic [39:0]   head;
    logic [7:0]    checksum;

    assign rec_ready = (fifo_count < FULL);
    assign push      = rec_valid && rec_ready;
    assign pop       = (state == IDLE) && (fifo_count != '0);
    assign head      = mem[rd_ptr];
    assign checksum  = head[39:32] ^ head[31:24] ^ head[23:16] ^ head[15:8] ^ head[7:0];

    function automatic logic [7:0] pkt_byte(input logic [55:0] p, input logic [2:0] i);
        case (i)
            3'd0:    return p[55:48];
            3'd1:    return p[47:40];
            3'd2:    return p[39:32];
            3'd3:    return p[31:24];
            3'd4:    return p[23:16];
            3'd5:    return p[15:8];
            3'd6:    return p[7:0];
            default: return 8'h00;
        endcase
    endfunction

    // Storage has no reset: only slots between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {rec_x, rec_y, rec_scale};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            packet         <= '0;
            index          <= '0;
            uart_data      <= 8'h00;
            send_uart_data <= 1'b0;
            busy           <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) begin
                fifo_count <= fifo_count + (AW+1)'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - (AW+1)'(1);
            end

            // Outputs are loaded on the edge entering SEND so the pulse and byte appear together.
            case (state)
                IDLE: begin
                    if (pop) begin
                        packet         <= {HEADER, head, checksum};
                        index          <= 3'd0;
                        uart_data      <= HEADER;
                        send_uart_data <= 1'b1;
                        busy           <= 1'b1;
                        state          <= SEND;
                    end
                end
                SEND: begin
                    send_uart_data <= 1'b0;
                    state          <= WAIT;
                end
                WAIT: begin
                    if (uart_data_sent) begin
                        if (index == 3'd6) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            index          <= index + 3'd1;
                            uart_data      <= pkt_byte(packet, index + 3'd1);
                            send_uart_data <= 1'b1;
                            state          <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_packet_sender.sv
// tb/tb_uart_packet_sender.sv - self-checking bench for uart_packet_sender
module tb_uart_packet_sender;
    localparam logic [7:0] HDR   = 8'hA5;
    localparam int         DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        rec_valid;
    logic [15:0] rec_x;
    logic [15:0] rec_y;
    logic [7:0]  rec_scale;
    logic        rec_ready;
    logic [7:0]  uart_data;
    logic        send_uart_data;
    logic        uart_data_sent;
    logic        busy;
    logic [2:0]  fifo_count;

    uart_packet_sender #(.HEADER(HDR), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .rec_valid      (rec_valid),
        .rec_x          (rec_x),
        .rec_y          (rec_y),
        .rec_scale      (rec_scale),
        .rec_ready      (rec_ready),
        .uart_data      (uart_data),
        .send_uart_data (send_uart_data),
        .uart_data_sent (uart_data_sent),
        .busy           (busy),
        .fifo_count     (fifo_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } rx_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  scale;
        logic [55:0] pkt;
    } vec_t;

    rx_t  got_q[$];
    rx_t  exp_q[$];
    vec_t vecs[5];
    int   n_cmp;
    int   n_fail;
    int   gi;
    bit   ack_en;
    int   ack_delay;
    bit   spur_on_send;
    int   spur_req;

    // Transmitter model: logs each pulse with its distance from the last real ack.
    int cyc;
    int ack_time;
    int ack_cnt;
    int spur_done;
    bit waiting;
    initial begin
        uart_data_sent = 1'b0;
        cyc = 0; ack_time = -100; ack_cnt = 0; spur_done = 0; waiting = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            uart_data_sent = 1'b0;
            if (reset) begin
                waiting = 1'b0;
            end else if (send_uart_data) begin
                rx_t r;
                r.data = uart_data;
                r.gap  = cyc - ack_time;
                got_q.push_back(r);
                waiting = 1'b1;
                ack_cnt = ack_delay;
                if (spur_on_send) uart_data_sent = 1'b1;
            end else if (waiting && ack_en) begin
                if (ack_cnt > 1) begin
                    ack_cnt--;
                end else begin
                    uart_data_sent = 1'b1;
                    waiting = 1'b0;
                    ack_time = cyc;
                end
            end else if (spur_req != spur_done) begin
                uart_data_sent = 1'b1;
                spur_done = spur_req;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic model_push(input logic [15:0] x, input logic [15:0] y, input logic [7:0] s,
                              input int hgap);
        logic [7:0] pay [5];
        logic [7:0] chk;
        rx_t e;
        pay[0] = x[15:8]; pay[1] = x[7:0]; pay[2] = y[15:8]; pay[3] = y[7:0]; pay[4] = s;
        chk = 8'h00;
        e.data = HDR; e.gap = hgap;
        exp_q.push_back(e);
        for (int k = 0; k < 5; k++) begin
            chk ^= pay[k];
            e.data = pay[k]; e.gap = 1;
            exp_q.push_back(e);
        end
        e.data = chk; e.gap = 1;
        exp_q.push_back(e);
    endtask

    task automatic push(input logic [15:0] x, input logic [15:0] y, input logic [7:0] s,
                        input int hgap, output bit acc);
        rec_valid = 1'b1; rec_x = x; rec_y = y; rec_scale = s;
        acc = rec_ready;
        @(negedge clock);
        rec_valid = 1'b0;
        if (acc) model_push(x, y, s, hgap);
    endtask

    task automatic push_hold(input logic [15:0] x, input logic [15:0] y, input logic [7:0] s);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 500) begin
            push(x, y, s, 0, acc);
            tries++;
        end
        if (!acc) check("push_timeout", 0, 1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (n < 3000 && !((got_q.size() - gi >= exp_q.size()) && !busy && fifo_count == 3'd0)) begin
            @(negedge clock);
            n++;
        end
        check({name, "_done"}, 32'(n < 3000), 1);
        check({name, "_nbytes"}, got_q.size() - gi, exp_q.size());
        foreach (exp_q[i]) begin
            if (gi + i < got_q.size()) begin
                check({name, "_byte"}, got_q[gi + i].data, exp_q[i].data);
                if (exp_q[i].gap != 0) check({name, "_gap"}, got_q[gi + i].gap, exp_q[i].gap);
            end
        end
        gi = got_q.size();
        exp_q.delete();
    endtask

    initial begin
        bit acc;
        int base;
        int n;
        reset = 1'b1; rec_valid = 1'b0; rec_x = '0; rec_y = '0; rec_scale = '0;
        ack_en = 1'b1; ack_delay = 3; spur_on_send = 1'b0; spur_req = 0;
        n_cmp = 0; n_fail = 0; gi = 0;

        vecs[0] = {16'h1234, 16'h00AB, 8'h05, 56'hA5_12_34_00_AB_05_88};
        vecs[1] = {16'h0000, 16'h0000, 8'h00, 56'hA5_00_00_00_00_00_00};
        vecs[2] = {16'hFFFF, 16'hFFFF, 8'hFF, 56'hA5_FF_FF_FF_FF_FF_FF};
        vecs[3] = {16'h0102, 16'h0408, 8'h10, 56'hA5_01_02_04_08_10_1F};
        vecs[4] = {16'h8001, 16'h7F00, 8'hC3, 56'hA5_80_01_7F_00_C3_3D};

        repeat (2) @(negedge clock);
        check("rst_ready", rec_ready, 1);
        check("rst_data", uart_data, 8'h00);
        check("rst_send", send_uart_data, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        reset = 1'b0;
        @(negedge clock);

        // Fixed packets, including the latency of the very first byte.
        for (int i = 0; i < 5; i++) begin
            base = got_q.size();
            push(vecs[i].x, vecs[i].y, vecs[i].scale, 0, acc);
            if (i == 0) begin
                check("lat_n_send", send_uart_data, 0);
                check("lat_n_count", fifo_count, 1);
                @(negedge clock);
                check("lat_n1_send", send_uart_data, 1);
                check("lat_n1_data", uart_data, HDR);
                check("lat_n1_busy", busy, 1);
                check("lat_n1_count", fifo_count, 0);
            end
            drain("table");
            if (got_q.size() >= base + 7) begin
                for (int k = 0; k < 7; k++) begin
                    check("table_vec", got_q[base + k].data, vecs[i].pkt[55 - 8*k -: 8]);
                end
            end
        end

        // Backlog with acks withheld: one popped, four queued, fifth rejected.
        ack_en = 1'b0; ack_delay = 2;
        for (int i = 0; i < 5; i++) begin
            push(16'($urandom), 16'($urandom), 8'($urandom), (i == 0) ? 0 : 2, acc);
            check("backlog_acc", acc, 1);
        end
        check("backlog_count", fifo_count, 4);
        check("backlog_ready", rec_ready, 0);
        push(16'hDEAD, 16'hBEEF, 8'h77, 0, acc);
        check("full_reject", acc, 0);
        check("full_count", fifo_count, 4);
        ack_en = 1'b1;
        drain("backlog");

        // Push coinciding with a pop at fifo_count=2.
        ack_en = 1'b0; ack_delay = 1;
        push(16'h1111, 16'h2222, 8'h33, 0, acc);
        push(16'h4444, 16'h5555, 8'h66, 2, acc);
        push(16'h7777, 16'h8888, 8'h99, 2, acc);
        check("pp_count_pre", fifo_count, 2);
        ack_en = 1'b1;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("pp_idle_seen", 32'(n < 500), 1);
        check("pp_idle_count", fifo_count, 2);
        push(16'hAAAA, 16'hBBBB, 8'hCC, 2, acc);
        check("pp_count_post", fifo_count, 2);
        drain("pushpop");

        // Spurious acks in IDLE and during every SEND cycle.
        ack_delay = 2;
        spur_req++;
        repeat (4) @(negedge clock);
        check("spur_idle_busy", busy, 0);
        check("spur_idle_pulses", got_q.size() - gi, 0);
        spur_on_send = 1'b1;
        push(16'h0F0F, 16'hF0F0, 8'h5A, 0, acc);
        drain("spurious");
        spur_on_send = 1'b0;

        // Reset while waiting on byte 3 with two records queued.
        ack_delay = 4;
        base = got_q.size();
        push(16'hCAFE, 16'hBABE, 8'h01, 0, acc);
        push(16'h1357, 16'h2468, 8'h02, 0, acc);
        push(16'h9ABC, 16'hDEF0, 8'h03, 0, acc);
        n = 0;
        while (got_q.size() - base < 4 && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("rst_mid_reached", 32'(n < 500), 1);
        check("rst_mid_queued", fifo_count, 2);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_send", send_uart_data, 0);
        check("rst_mid_data", uart_data, 8'h00);
        check("rst_mid_count", fifo_count, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", rec_ready, 1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        gi = got_q.size();
        repeat (10) @(negedge clock);
        check("rst_no_resume", got_q.size() - gi, 0);
        check("rst_no_resume_busy", busy, 0);
        base = gi;
        push(16'h0246, 16'h8ACE, 8'h11, 0, acc);
        drain("post_reset");
        if (got_q.size() > base) check("post_reset_hdr", got_q[base].data, 8'hA5);

        // Randomised records, ack delays and push spacing.
        for (int i = 0; i < 24; i++) begin
            ack_delay = $urandom_range(1, 4);
            push_hold(16'($urandom), 16'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 8)) @(negedge clock);
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_packet_sender.md
UART_PACKET_SENDER -- requirements
Module: uart_packet_sender

Interface
REQ-001 The block SHALL have parameter HEADER, default 8'hA5, the packet start byte.
REQ-002 The block SHALL have parameter DEPTH, default 4, the record FIFO depth (power of two, 2..16).
REQ-003 The block SHALL have port clock  input  1  rising-edge system clock.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port rec_valid  input  1  detection record offered.
REQ-006 The block SHALL have port rec_x  input  16  record x coordinate.
REQ-007 The block SHALL have port rec_y  input  16  record y coordinate.
REQ-008 The block SHALL have port rec_scale  input  8  record scale index.
REQ-009 The block SHALL have port rec_ready  output  1  FIFO can accept a record.
REQ-010 The block SHALL have port uart_data  output  8  byte to the UART transmitter.
REQ-011 The block SHALL have port send_uart_data  output  1  one-cycle start pulse to the transmitter.
REQ-012 The block SHALL have port uart_data_sent  input  1  transmitter byte-done pulse.
REQ-013 The block SHALL have port busy  output  1  packet in progress.
REQ-014 The block SHALL have port fifo_count  output  $clog2(DEPTH)+1  records queued.

Function
REQ-015 A record SHALL be accepted on any rising clock edge with rec_valid=1 and rec_ready=1; rec_ready SHALL be 1 exactly when fifo_count<DEPTH.
REQ-016 The FIFO SHALL be first-in first-out, pointers wrapping modulo DEPTH; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-017 Each record SHALL be sent as a 7-byte packet, in order: HEADER, x[15:8], x[7:0], y[15:8], y[7:0], scale, checksum.
REQ-018 Checksum SHALL be the bitwise XOR of the five payload bytes (header excluded).
REQ-019 FSM states SHALL be IDLE, SEND, WAIT.
REQ-020 IDLE: if fifo_count>0, pop the head record into an internal packet register, clear byte index to 0, go to SEND; otherwise stay.
REQ-021 SEND: drive uart_data=packet byte[index], assert send_uart_data for exactly this one cycle, go to WAIT.
REQ-022 WAIT: on uart_data_sent=1, if index=6 go to IDLE, else increment index and go to SEND; otherwise stay.
REQ-023 uart_data SHALL be registered and stable from the SEND cycle until the next SEND cycle.
REQ-024 uart_data_sent SHALL be ignored in IDLE and SEND.
REQ-025 busy SHALL be 1 in SEND and WAIT, 0 in IDLE.
REQ-026 Latency: a record pushed into an empty FIFO at edge N SHALL produce send_uart_data=1 in the cycle after edge N+1 (popped at N+1).
REQ-027 Each subsequent byte SHALL start exactly one cycle after the uart_data_sent pulse that ends the previous byte.
REQ-028 Back-to-back packets SHALL have exactly one IDLE cycle between the last uart_data_sent and the next packet's header pulse.
REQ-029 Records pushed while full SHALL NOT be accepted (rec_ready=0); the upstream holds them.

Reset
REQ-030 On reset=1, asynchronously: state=IDLE, FIFO empty (fifo_count=0), pointers=0, index=0.
REQ-031 Reset values: rec_ready=1, uart_data=8'h00, send_uart_data=0, busy=0.
REQ-032 Reset mid-packet SHALL abandon the packet and flush queued records; no partial-packet resumption after release.

Verification
REQ-033 Single record x=16'h1234, y=16'h00AB, scale=8'h05, transmitter acks 3 cycles after each pulse -> bytes A5,12,34,00,AB,05,88, one pulse each, busy low after seventh ack.
REQ-034 Push 5 records with ack withheld (DEPTH=4) -> first popped, 4 queued, rec_ready=0, fifo_count=4; release acks -> 5 packets in push order, fifo_count reaches 0.
REQ-035 Push and pop in same cycle with fifo_count=2 -> fifo_count stays 2, record order preserved.
REQ-036 Spurious uart_data_sent pulses while IDLE and in SEND -> no state change, index not advanced, no extra send_uart_data.
REQ-037 Assert reset during WAIT of byte 3 with 2 records queued -> send_uart_data=0, uart_data=00, fifo_count=0, busy=0 immediately; new record after release sends fresh header A5.
REQ-038 Record all-zero (x=0,y=0,scale=0) -> packet A5,00,00,00,00,00,00.
